// File: rtl/i2c_slave.sv
// I2C slave with 8-bit register pointer: the first write byte sets the pointer,
// later bytes write at the pointer and reads stream from it, both auto-incrementing.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h58
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [6:0] shift, shift_n;
  logic       oe_q, oe_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] wdata, wdata_n;
  logic       we_q, we_n;
  logic       busy_q, busy_n;
  logic       first, first_n;
  logic       rw, rw_n;
  logic       acked, acked_n;
  logic [7:0] byte_in;

  assign byte_in = {shift, sda_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shift  <= '0;
      oe_q   <= 1'b0;
      ptr    <= '0;
      wdata  <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      first  <= 1'b0;
      rw     <= 1'b0;
      acked  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      oe_q   <= oe_n;
      ptr    <= ptr_n;
      wdata  <= wdata_n;
      we_q   <= we_n;
      busy_q <= busy_n;
      first  <= first_n;
      rw     <= rw_n;
      acked  <= acked_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    oe_n    = oe_q;
    ptr_n   = ptr;
    wdata_n = wdata;
    we_n    = 1'b0;
    busy_n  = busy_q;
    first_n = first;
    rw_n    = rw;
    acked_n = acked;

    // Pointer advances the cycle after the write strobe so the strobe sees the old address
    if (we_q) ptr_n = ptr + 8'd1;

    if (stop_det) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      acked_n = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      acked_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n = byte_in[6:0];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = '0;
              rw_n  = byte_in[0];
              if (byte_in[7:1] == ADDR) begin
                state_n = ST_ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n = ST_WAIT;
              end
            end
          end
        end
        // oe_q tells the fall that starts the ACK slot from the one that ends it
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_n = 1'b1;
            end else if (rw) begin
              state_n = ST_RD_BYTE;
              shift_n = reg_rdata[6:0];
              oe_n    = ~reg_rdata[7];
              cnt_n   = 4'd1;
            end else begin
              state_n = ST_WR_BYTE;
              oe_n    = 1'b0;
              first_n = 1'b1;
              cnt_n   = '0;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_n = byte_in[6:0];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n   = '0;
              state_n = ST_WR_ACK;
              if (first) begin
                ptr_n   = byte_in;
                first_n = 1'b0;
              end else begin
                wdata_n = byte_in;
                we_n    = 1'b1;
              end
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_n = 1'b1;
            end else begin
              oe_n    = 1'b0;
              state_n = ST_WR_BYTE;
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              acked_n = 1'b0;
              state_n = ST_RD_ACK;
            end else begin
              oe_n    = ~shift[6];
              shift_n = {shift[5:0], 1'b0};
              cnt_n   = cnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_n   = ptr + 8'd1;
              acked_n = 1'b1;
            end else begin
              state_n = ST_WAIT;
              busy_n  = 1'b0;
              oe_n    = 1'b0;
            end
          end else if (scl_fall && acked) begin
            state_n = ST_RD_BYTE;
            shift_n = reg_rdata[6:0];
            oe_n    = ~reg_rdata[7];
            cnt_n   = 4'd1;
            acked_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Detected START/STOP releases the line in the same cycle, ahead of the register
  assign sda_oe    = oe_q & ~(start_det | stop_det);
  assign reg_addr  = ptr;
  assign reg_wdata = wdata;
  assign reg_we    = we_q;
  assign busy      = busy_q;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter: ADDR, default 7'h58, 7-bit bus address the block responds to.
REQ-002 clk  input  1  system clock; at least 16x the SCL frequency.
REQ-003 reset  input  1  asynchronous, active-low; 0 resets all state.
REQ-004 scl  input  1  I2C clock from the bus master.
REQ-005 sda_in  input  1  I2C data as sampled from the pad.
REQ-006 sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
REQ-007 reg_addr  output  8  register pointer; selects reg_rdata and the reg_we target.
REQ-008 reg_wdata  output  8  write data, valid while reg_we=1.
REQ-009 reg_we  output  1  single-clk write strobe.
REQ-010 reg_rdata  input  8  read data for reg_addr, combinational or settled within 2 clk.
REQ-011 busy  output  1  1 from the address match until STOP, START or NACK termination.

Function
REQ-012 scl and sda_in SHALL pass through 2-flop synchronizers that reset to 1; all logic uses the synchronized values.
REQ-013 Edge detect: scl_rise and scl_fall from the synced scl; START = synced SDA 1->0 while SCL=1; STOP = synced SDA 0->1 while SCL=1.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT.
REQ-015 Bits SHALL be sampled on scl_rise, MSB first; sda_oe SHALL change only on scl_fall, or on STOP, START or reset.
REQ-016 START in any state (including a repeated START) -> ADDR with bit count 0 and sda_oe=0; the pointer is retained.
REQ-017 STOP in any state -> IDLE with sda_oe=0 and busy=0; a partial byte is discarded.
REQ-018 ADDR: after 8 bits, if byte[7:1]==ADDR, assert sda_oe on the next scl_fall (ACK) and set busy=1.
REQ-019 ADDR with no match: go to WAIT with no ACK; WAIT ignores everything except START and STOP.
REQ-020 At the scl_fall ending the ACK slot, release sda_oe, then branch on R/W.
REQ-021 R/W=0 -> WR_BYTE with first_byte=1.
REQ-022 R/W=1 -> RD_BYTE: load shift reg from reg_rdata at that scl_fall and drive sda_oe = ~bit7 in the same cycle.
REQ-023 WR_BYTE, byte completes on the 8th scl_rise: if first_byte, pointer <= byte and first_byte=0.
REQ-024 WR_BYTE otherwise: reg_wdata <= byte and reg_we=1 for exactly 1 clk at the current pointer; pointer then increments.
REQ-025 After either WR_BYTE case, ACK on the next scl_fall (WR_ACK) and release on the following scl_fall.
REQ-026 Pointer increment is mod 256 (8'hFF -> 8'h00).
REQ-027 RD_BYTE: shift and drive each bit on scl_fall; after the 8th bit, release sda_oe on scl_fall (RD_ACK).
REQ-028 RD_ACK, on scl_rise: master ACK (SDA=0) -> pointer+1, next byte loaded at the next scl_fall; NACK -> WAIT, busy=0, sda_oe=0.
REQ-029 reg_addr SHALL equal the pointer at all times and be stable at least from the scl_rise preceding any reg_rdata load.
REQ-030 A START or STOP arriving while sda_oe=1 SHALL release sda_oe in the same clk it is detected.

Reset
REQ-031 While reset=0: state=IDLE, sda_oe=0, reg_we=0, busy=0, reg_addr=8'h00, reg_wdata=8'h00, bit count 0, synchronizers=1, asynchronously.
REQ-032 After reset is released, the block SHALL act only on a new START.

Verification
REQ-033 Write 0xB0 (0x58, W), 0x30, 0x08, 0x90, STOP -> 4 ACKs; reg_we pulses at (0x30,0x08) and (0x31,0x90); reg_addr=0x32.
REQ-034 Write 0x42 (0x21, W), 0x10 -> sda_oe never 1; no reg_we; busy stays 0.
REQ-035 Model reg_rdata = reg_addr^0xA5: write 0xB0, 0x36, repeated START, 0xB1, read with ACK,ACK,NACK -> SDA carries 0x93, 0x92, 0x9D; then WAIT with sda_oe=0.
REQ-036 Pointer 0xFF: write 0xB0, 0xFF, 0x11, 0x22 -> reg_we at (0xFF,0x11) then (0x00,0x22).
REQ-037 reset=0 mid read while sda_oe=1 -> sda_oe=0 in the same cycle; after release, reg_addr=0x00 and the block ignores bits until START.
REQ-038 STOP after 4 bits of a data byte -> no reg_we, state IDLE, pointer unchanged.
